// File: rtl/uart_word_rx_pkg.sv
// Shared constants and helpers for the UART word receiver.
// Latency: n/a (package only).
// Backpressure: n/a.
package uart_word_rx_pkg;

   // Clock cycles per UART bit when the instantiating design does not override BAUD.
   localparam int DEFAULT_BAUD = 16;

   // Returns `shift` with byte `b` written into lane `idx`.
   // Lane 0 is bits [31:24], so the first byte received becomes the most significant byte.
   function automatic logic [31:0] place_byte(input logic [31:0] shift,
                                              input logic [1:0]  idx,
                                              input logic [7:0]  b);
      logic [31:0] r;
      r = shift;
      case (idx)
         2'd0:    r[31:24] = b;
         2'd1:    r[23:16] = b;
         2'd2:    r[15:8]  = b;
         default: r[7:0]   = b;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/uart_word_rx_uart_rx.sv
// uart_rx: 2-flop synchroniser plus 8N1 byte deserialiser.
// Latency: byte_valid/byte_err are registered one cycle after the mid-stop-bit sample.
// Backpressure: none; byte_valid and byte_err are single-cycle pulses that must be taken.
// Ports:
//   clk, rstn  - system clock and asynchronous active-low reset
//   rx         - asynchronous serial input, idles high
//   byte_data  - last received byte, LSB received first
//   byte_valid - pulse when a frame ends with a good (high) stop bit
//   byte_err   - pulse when the stop bit samples low
module uart_rx
   import uart_word_rx_pkg::*;
#(
   parameter int BAUD = DEFAULT_BAUD
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       rx,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   output logic       byte_err
);

   localparam int CW = $clog2(BAUD);
   localparam logic [CW-1:0] HALF_M1 = CW'(BAUD / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(BAUD - 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_START     = 3'd1;
   localparam logic [2:0] S_DATA      = 3'd2;
   localparam logic [2:0] S_STOP      = 3'd3;
   localparam logic [2:0] S_WAIT_HIGH = 3'd4;

   logic [1:0]    sync_q;
   logic          rxs;
   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    data_q, data_d;
   logic          valid_q, valid_d;
   logic          err_q, err_d;
   logic          cnt_zero;

   assign rxs      = sync_q[1];
   assign cnt_zero = (cnt_q == '0);

   // Both synchroniser flops reset high, so reset never looks like a start bit.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], rx};
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      data_d  = data_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!rxs) begin
               state_d = S_START;
               cnt_d   = HALF_M1;
            end
         end
         S_START: begin
            if (cnt_zero) begin
               // Line went high again before mid-start: treat it as a glitch.
               if (!rxs) begin
                  state_d = S_DATA;
                  cnt_d   = FULL_M1;
                  bit_d   = 3'd0;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_DATA: begin
            if (cnt_zero) begin
               data_d = {rxs, data_q[7:1]};
               cnt_d  = FULL_M1;
               if (bit_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_STOP: begin
            if (cnt_zero) begin
               if (rxs) begin
                  valid_d = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_WAIT_HIGH;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_WAIT_HIGH: begin
            // A held-low line (break) must return high before a new start is accepted.
            if (rxs) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      byte_data  = data_q;
      byte_valid = valid_q;
      byte_err   = err_q;
   end

endmodule

// File: rtl/uart_word_rx.sv
// uart_word_rx: packs four received UART bytes into a 32-bit word, first byte in [31:24].
// Latency: word_valid/frame_err/overrun rise one cycle after the fourth byte_valid or a byte_err.
// Backpressure: valid/ready on word; a word completed while one is still pending is dropped
//               and reported on overrun.
// Ports:
//   clk, rstn             - system clock and asynchronous active-low reset
//   rx                    - asynchronous serial input, idles high
//   word, word_valid      - assembled word and its valid flag (word held while valid)
//   word_ready            - consumer accepts when word_valid && word_ready
//   frame_err, overrun    - single-cycle event pulses
module uart_word_rx
   import uart_word_rx_pkg::*;
#(
   parameter int BAUD = DEFAULT_BAUD
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        rx,
   output logic [31:0] word,
   output logic        word_valid,
   input  logic        word_ready,
   output logic        frame_err,
   output logic        overrun
);

   logic [7:0]  byte_data;
   logic        byte_valid;
   logic        byte_err;

   logic [31:0] shift_q, shift_d;
   logic [1:0]  idx_q, idx_d;
   logic [31:0] word_q, word_d;
   logic        word_vld_q, word_vld_d;
   logic        frame_err_q, frame_err_d;
   logic        overrun_q, overrun_d;
   logic        handshake;
   logic [31:0] cand;

   uart_rx #(.BAUD(BAUD)) u_uart_rx (
      .clk        (clk),
      .rstn       (rstn),
      .rx         (rx),
      .byte_data  (byte_data),
      .byte_valid (byte_valid),
      .byte_err   (byte_err)
   );

   assign handshake = word_vld_q & word_ready;
   assign cand      = place_byte(shift_q, idx_q, byte_data);

   always_comb begin
      shift_d     = shift_q;
      idx_d       = idx_q;
      word_d      = word_q;
      word_vld_d  = word_vld_q;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;

      if (handshake) begin
         word_vld_d = 1'b0;
      end

      if (byte_err) begin
         // The partial word is abandoned; a pending output word is untouched.
         frame_err_d = 1'b1;
         idx_d       = 2'd0;
      end else if (byte_valid) begin
         shift_d = cand;
         idx_d   = idx_q + 2'd1;
         if (idx_q == 2'd3) begin
            // The output slot is free if empty or being consumed this same cycle.
            if (!word_vld_q || handshake) begin
               word_d     = cand;
               word_vld_d = 1'b1;
            end else begin
               overrun_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         shift_q     <= '0;
         idx_q       <= '0;
         word_q      <= '0;
         word_vld_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         shift_q     <= shift_d;
         idx_q       <= idx_d;
         word_q      <= word_d;
         word_vld_q  <= word_vld_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign word       = word_q;
   assign word_valid = word_vld_q;
   assign frame_err  = frame_err_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_word_rx.sv
// Bench for uart_word_rx: serial stimulus against a byte-level model of word assembly.
// Latency: n/a.
// Backpressure: word_ready is held high except in the overrun scenario.
module tb_uart_word_rx;

   localparam int BAUD = 16;

   logic        clk;
   logic        rstn;
   logic        rx;
   logic [31:0] word;
   logic        word_valid;
   logic        word_ready;
   logic        frame_err;
   logic        overrun;

   uart_word_rx #(.BAUD(BAUD)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .rx         (rx),
      .word       (word),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .frame_err  (frame_err),
      .overrun    (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: bytes accumulate MSB-first; every fourth good byte makes a word.
   logic [31:0] exp_q[$];
   logic [31:0] m_part  = '0;
   int          m_cnt   = 0;
   bit          m_hold  = 1'b0;
   bit          m_pend  = 1'b0;
   int          fe_exp  = 0;
   int          ov_exp  = 0;
   int          fe_seen = 0;
   int          ov_seen = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic model_byte(input logic [7:0] b, input bit stop_ok);
      if (!stop_ok) begin
         fe_exp++;
         m_cnt = 0;
      end else begin
         m_part = {m_part[23:0], b};
         m_cnt++;
         if (m_cnt == 4) begin
            m_cnt = 0;
            if (m_hold && m_pend) begin
               ov_exp++;
            end else begin
               exp_q.push_back(m_part);
               if (m_hold) m_pend = 1'b1;
            end
         end
      end
   endtask

   // A bad frame is followed by one bit time of idle so the receiver can leave WAIT_HIGH.
   task automatic send_byte(input logic [7:0] b, input bit stop_ok);
      rx = 1'b0;
      tick(BAUD);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(BAUD);
      end
      model_byte(b, stop_ok);
      rx = stop_ok;
      tick(BAUD);
      if (!stop_ok) begin
         rx = 1'b1;
         tick(BAUD);
      end
      rx = 1'b1;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) begin
         send_byte(w[8*i +: 8], 1'b1);
      end
   endtask

   task automatic end_of_test(input string name);
      rx = 1'b1;
      tick(3 * BAUD);
      check_val({name, "_pending_words"}, 32'(exp_q.size()), 32'd0);
      check_val({name, "_frame_err_cnt"}, 32'(fe_seen), 32'(fe_exp));
      check_val({name, "_overrun_cnt"},   32'(ov_seen), 32'(ov_exp));
   endtask

   // Monitor samples mid-cycle, so valid && ready here is the handshake of the next edge.
   always @(negedge clk) begin
      if (rstn) begin
         if (frame_err) fe_seen++;
         if (overrun)   ov_seen++;
         if (word_valid && word_ready) begin
            check_val("word_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               check_val("word_value", word, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rstn       = 1'b0;
      rx         = 1'b1;
      word_ready = 1'b1;
      tick(4);
      @(negedge clk);
      check_val("reset_word",       word,       32'h0);
      check_val("reset_word_valid", {31'b0, word_valid}, 32'h0);
      check_val("reset_frame_err",  {31'b0, frame_err},  32'h0);
      check_val("reset_overrun",    {31'b0, overrun},    32'h0);
      tick(1);
      rstn = 1'b1;
      tick(2 * BAUD);

      // Back-to-back bytes forming one word.
      send_byte(8'ha1, 1'b1);
      send_byte(8'h4e, 1'b1);
      send_byte(8'h28, 1'b1);
      send_byte(8'hc5, 1'b1);
      end_of_test("basic");

      // Framing error discards the partial word.
      send_byte(8'h01, 1'b1);
      send_byte(8'h02, 1'b1);
      send_byte(8'h7e, 1'b0);
      send_word(32'h11223344);
      end_of_test("framing");

      // Overrun while the consumer stalls.
      word_ready = 1'b0;
      m_hold     = 1'b1;
      m_pend     = 1'b0;
      send_word(32'hdeadbeef);
      send_word(32'h12345678);
      tick(2 * BAUD);
      @(negedge clk);
      check_val("stall_valid", {31'b0, word_valid}, 32'h1);
      check_val("stall_word",  word, 32'hdeadbeef);
      check_val("stall_overrun_cnt", 32'(ov_seen), 32'(ov_exp));
      tick(1);
      word_ready = 1'b1;
      m_hold     = 1'b0;
      m_pend     = 1'b0;
      tick(2);
      check_val("stall_cleared", {31'b0, word_valid}, 32'h0);
      end_of_test("overrun");

      // Short low glitch must not start a byte.
      rx = 1'b0;
      tick(3);
      rx = 1'b1;
      tick(2 * BAUD);
      send_word(32'h00000000);
      end_of_test("glitch");

      // Reset in the middle of the second byte.
      send_byte(8'h99, 1'b1);
      rx = 1'b0;
      tick(BAUD);
      for (int i = 0; i < 4; i++) begin
         rx = i[0];
         tick(BAUD);
      end
      rx   = 1'b1;
      rstn = 1'b0;
      m_cnt = 0;
      tick(3);
      @(negedge clk);
      check_val("midreset_valid",     {31'b0, word_valid}, 32'h0);
      check_val("midreset_frame_err", {31'b0, frame_err},  32'h0);
      tick(1);
      rstn = 1'b1;
      tick(2 * BAUD);
      send_word(32'hcafef00d);
      end_of_test("midreset");

      // Break: line low for 20 bit times.
      fe_exp++;
      m_cnt = 0;
      rx = 1'b0;
      tick(20 * BAUD);
      rx = 1'b1;
      tick(2 * BAUD);
      send_word(32'h5a5a5a5a);
      end_of_test("break");

      // Random bytes, occasional bad stop bits and random idle gaps.
      for (int w = 0; w < 80; w++) begin
         logic [7:0] b;
         bit         ok;
         b  = 8'($urandom_range(0, 255));
         ok = ($urandom_range(0, 9) != 0);
         send_byte(b, ok);
         tick($urandom_range(0, 20));
      end
      end_of_test("random");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
